// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and the swap-sequencer state encoding for
//                the register file with hardware register swap.
//                Default widths are also consumed by the instruction decoder.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    // Default datapath geometry shared with the decoder
    localparam int unsigned RF_W     = 8;
    localparam int unsigned RF_D     = 4;
    localparam int unsigned RF_IMM_W = 6;

    // Swap sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWAP_A = 2'd1,
        SWAP_B = 2'd2
    } swap_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_swap_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_swap_seq_if
//  Description : Decoder <-> register file bundle: three read ports, one
//                external write port, immediate load, swap request and the
//                swap status outputs.
//  Modports    : master - decoder side (drives addresses/enables, reads data)
//                slave  - register file side
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_swap_seq_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned D     = 4,
    parameter int unsigned IMM_W = 6
) ();

    logic [D-1:0]     RdAddrA;
    logic [D-1:0]     RdAddrB;
    logic [D-1:0]     RdAddrC;
    logic [W-1:0]     DataOutA;
    logic [W-1:0]     DataOutB;
    logic [W-1:0]     DataOutC;
    logic             WrEn;
    logic [D-1:0]     WrAddr;
    logic [W-1:0]     DataIn;
    logic             LoadImmEn;
    logic [IMM_W-1:0] Imm;
    logic             SwapReq;
    logic [D-1:0]     SwapAddrX;
    logic [D-1:0]     SwapAddrY;
    logic             Busy;
    logic             SwapDone;

    modport master (
        output RdAddrA, RdAddrB, RdAddrC,
        output WrEn, WrAddr, DataIn,
        output LoadImmEn, Imm,
        output SwapReq, SwapAddrX, SwapAddrY,
        input  DataOutA, DataOutB, DataOutC,
        input  Busy, SwapDone
    );

    modport slave (
        input  RdAddrA, RdAddrB, RdAddrC,
        input  WrEn, WrAddr, DataIn,
        input  LoadImmEn, Imm,
        input  SwapReq, SwapAddrX, SwapAddrY,
        output DataOutA, DataOutB, DataOutC,
        output Busy, SwapDone
    );

endinterface : regfile_swap_seq_if
`default_nettype wire

// File: rtl/regfile_swap_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rf_swap_ctrl
//  Description : Two-cycle register swap sequencer. Latches the operands in
//                IDLE, then steers the shared write port:
//                  SWAP_A : tmp <= R[X], R[X] <= R[Y]
//                  SWAP_B : R[Y] <= tmp
//  Ports       : clk_i, rst_i         clock, synchronous active-high reset
//                swap_req_i           swap request (sampled in IDLE only)
//                swap_addr_x/y_i      swap operands
//                busy_o               sequencer owns the write port
//                swap_done_o          registered pulse after SWAP_B
//                swap_wr_o            sequencer write this cycle
//                swap_wr_addr_o       sequencer write address
//                swap_src_addr_o      register supplying write data (SWAP_A)
//                swap_src_tmp_o       write data comes from tmp (SWAP_B)
//                tmp_cap_o/tmp_addr_o capture R[tmp_addr_o] into tmp
//  Revision    : 1.0  initial release
// ============================================================================
module rf_swap_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned D = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         swap_req_i,
    input  logic [D-1:0] swap_addr_x_i,
    input  logic [D-1:0] swap_addr_y_i,
    output logic         busy_o,
    output logic         swap_done_o,
    output logic         swap_wr_o,
    output logic [D-1:0] swap_wr_addr_o,
    output logic [D-1:0] swap_src_addr_o,
    output logic         swap_src_tmp_o,
    output logic         tmp_cap_o,
    output logic [D-1:0] tmp_addr_o
);

    swap_state_e  state_q, state_d;
    logic [D-1:0] x_q, x_d;
    logic [D-1:0] y_q, y_d;
    logic         done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        done_d          = 1'b0;
        swap_wr_o       = 1'b0;
        swap_wr_addr_o  = '0;
        swap_src_addr_o = '0;
        swap_src_tmp_o  = 1'b0;
        tmp_cap_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (swap_req_i) begin
                    x_d     = swap_addr_x_i;
                    y_d     = swap_addr_y_i;
                    state_d = SWAP_A;
                end
            end
            SWAP_A: begin
                // tmp and R[X] both sample the pre-edge array, so X == Y is safe
                tmp_cap_o       = 1'b1;
                swap_wr_o       = 1'b1;
                swap_wr_addr_o  = x_q;
                swap_src_addr_o = y_q;
                state_d         = SWAP_B;
            end
            SWAP_B: begin
                swap_wr_o      = 1'b1;
                swap_wr_addr_o = y_q;
                swap_src_tmp_o = 1'b1;
                done_d         = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign swap_done_o = done_q;
    assign tmp_addr_o  = x_q;

endmodule : rf_swap_ctrl
`default_nettype wire

// File: rtl/regfile_swap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_swap_seq
//  Description : W x 2**D register file, three asynchronous read ports, one
//                shared synchronous write port, immediate load into IMM_REG
//                and a hardware-sequenced two-cycle swap through a private
//                temp register. Optional same-cycle write-to-read bypass.
//  Ports       : Clk    clock (rising edge)
//                Reset  synchronous active-high reset
//                rf_bus decoder bundle (slave side): read addresses/data,
//                       write port, immediate load, swap request, Busy,
//                       SwapDone
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_swap_seq
    import regfile_pkg::*;
#(
    parameter int unsigned W       = RF_W,
    parameter int unsigned D       = RF_D,
    parameter int unsigned IMM_W   = RF_IMM_W,
    parameter int unsigned IMM_REG = 0,
    parameter int unsigned BYPASS  = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    regfile_swap_seq_if.slave  rf_bus
);

    localparam int unsigned NREG = 2 ** D;

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] tmp_q;

    logic         busy;
    logic         swap_done;
    logic         swap_wr;
    logic [D-1:0] swap_wr_addr;
    logic [D-1:0] swap_src_addr;
    logic         swap_src_tmp;
    logic         tmp_cap;
    logic [D-1:0] tmp_addr;

    logic         wr_en_d;
    logic [D-1:0] wr_addr_d;
    logic [W-1:0] wr_data_d;
    logic [W-1:0] imm_ext;
    logic [W-1:0] rd_a, rd_b, rd_c;

    rf_swap_ctrl #(
        .D (D)
    ) u_swap_ctrl (
        .clk_i           (Clk),
        .rst_i           (Reset),
        .swap_req_i      (rf_bus.SwapReq),
        .swap_addr_x_i   (rf_bus.SwapAddrX),
        .swap_addr_y_i   (rf_bus.SwapAddrY),
        .busy_o          (busy),
        .swap_done_o     (swap_done),
        .swap_wr_o       (swap_wr),
        .swap_wr_addr_o  (swap_wr_addr),
        .swap_src_addr_o (swap_src_addr),
        .swap_src_tmp_o  (swap_src_tmp),
        .tmp_cap_o       (tmp_cap),
        .tmp_addr_o      (tmp_addr)
    );

    always_comb begin
        imm_ext              = '0;
        imm_ext[IMM_W-1:0]   = rf_bus.Imm;
    end

    // Single write port arbitration: sequencer owns it while busy, external
    // requests during that window are dropped. In IDLE the immediate wins.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (busy) begin
            wr_en_d   = swap_wr;
            wr_addr_d = swap_wr_addr;
            wr_data_d = swap_src_tmp ? tmp_q : regs_q[swap_src_addr];
        end else if (rf_bus.LoadImmEn) begin
            wr_en_d   = 1'b1;
            wr_addr_d = D'(IMM_REG);
            wr_data_d = imm_ext;
        end else if (rf_bus.WrEn) begin
            wr_en_d   = 1'b1;
            wr_addr_d = rf_bus.WrAddr;
            wr_data_d = rf_bus.DataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            tmp_q <= '0;
        end else begin
            if (tmp_cap) begin
                tmp_q <= regs_q[tmp_addr];
            end
            if (wr_en_d) begin
                regs_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    // Reads; the bypass path forwards whatever the write port commits now
    always_comb begin
        rd_a = regs_q[rf_bus.RdAddrA];
        rd_b = regs_q[rf_bus.RdAddrB];
        rd_c = regs_q[rf_bus.RdAddrC];
        if (BYPASS != 0 && wr_en_d) begin
            if (wr_addr_d == rf_bus.RdAddrA) rd_a = wr_data_d;
            if (wr_addr_d == rf_bus.RdAddrB) rd_b = wr_data_d;
            if (wr_addr_d == rf_bus.RdAddrC) rd_c = wr_data_d;
        end
    end

    assign rf_bus.DataOutA = rd_a;
    assign rf_bus.DataOutB = rd_b;
    assign rf_bus.DataOutC = rd_c;
    assign rf_bus.Busy     = busy;
    assign rf_bus.SwapDone = swap_done;

endmodule : regfile_swap_seq
`default_nettype wire

// File: tb/tb_regfile_swap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_swap_seq
//  Description : Self-checking bench for regfile_swap_seq. Two instances are
//                driven with identical stimulus, one with bypass and one
//                without, and compared every cycle against a behavioural
//                model of the register file.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_swap_seq;
    import regfile_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    regfile_swap_seq_if rf1 ();
    regfile_swap_seq_if rf0 ();

    regfile_swap_seq #(.BYPASS(1)) dut    (.Clk(Clk), .Reset(Reset), .rf_bus(rf1));
    regfile_swap_seq #(.BYPASS(0)) dut_nb (.Clk(Clk), .Reset(Reset), .rf_bus(rf0));

    assign rf0.RdAddrA   = rf1.RdAddrA;
    assign rf0.RdAddrB   = rf1.RdAddrB;
    assign rf0.RdAddrC   = rf1.RdAddrC;
    assign rf0.WrEn      = rf1.WrEn;
    assign rf0.WrAddr    = rf1.WrAddr;
    assign rf0.DataIn    = rf1.DataIn;
    assign rf0.LoadImmEn = rf1.LoadImmEn;
    assign rf0.Imm       = rf1.Imm;
    assign rf0.SwapReq   = rf1.SwapReq;
    assign rf0.SwapAddrX = rf1.SwapAddrX;
    assign rf0.SwapAddrY = rf1.SwapAddrY;

    int checks = 0;
    int errors = 0;

    // Behavioural model: register array, temp, swap progress, done pulse
    logic [7:0] mdl [16];
    logic [7:0] mtmp;
    int         phase;     // 0 idle, 1 first swap cycle, 2 second swap cycle
    logic [3:0] sx, sy;
    bit         done_exp;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rf1.RdAddrA   = 4'd0;
        rf1.RdAddrB   = 4'd0;
        rf1.RdAddrC   = 4'd0;
        rf1.WrEn      = 1'b0;
        rf1.WrAddr    = 4'd0;
        rf1.DataIn    = 8'd0;
        rf1.LoadImmEn = 1'b0;
        rf1.Imm       = 6'd0;
        rf1.SwapReq   = 1'b0;
        rf1.SwapAddrX = 4'd0;
        rf1.SwapAddrY = 4'd0;
    endtask

    task automatic model_reset();
        foreach (mdl[i]) mdl[i] = 8'h00;
        mtmp     = 8'h00;
        phase    = 0;
        sx       = 4'd0;
        sy       = 4'd0;
        done_exp = 1'b0;
    endtask

    // One clock: check all outputs against the model, then advance the model
    task automatic cycle();
        bit         en;
        logic [3:0] wa;
        logic [7:0] wd;
        #1;
        en = 1'b0; wa = 4'd0; wd = 8'd0;
        if (phase == 1) begin
            en = 1'b1; wa = sx; wd = mdl[sy];
        end else if (phase == 2) begin
            en = 1'b1; wa = sy; wd = mtmp;
        end else if (rf1.LoadImmEn) begin
            en = 1'b1; wa = 4'd0; wd = {2'b00, rf1.Imm};
        end else if (rf1.WrEn) begin
            en = 1'b1; wa = rf1.WrAddr; wd = rf1.DataIn;
        end
        chk("rdA_byp", rf1.DataOutA, (en && wa == rf1.RdAddrA) ? wd : mdl[rf1.RdAddrA]);
        chk("rdB_byp", rf1.DataOutB, (en && wa == rf1.RdAddrB) ? wd : mdl[rf1.RdAddrB]);
        chk("rdC_byp", rf1.DataOutC, (en && wa == rf1.RdAddrC) ? wd : mdl[rf1.RdAddrC]);
        chk("rdA_nb",  rf0.DataOutA, mdl[rf1.RdAddrA]);
        chk("rdB_nb",  rf0.DataOutB, mdl[rf1.RdAddrB]);
        chk("rdC_nb",  rf0.DataOutC, mdl[rf1.RdAddrC]);
        chk("busy",    8'(rf1.Busy),     8'(phase != 0));
        chk("done",    8'(rf1.SwapDone), 8'(done_exp));
        chk("busy_nb", 8'(rf0.Busy),     8'(phase != 0));
        chk("done_nb", 8'(rf0.SwapDone), 8'(done_exp));
        @(posedge Clk);
        if (Reset) begin
            model_reset();
        end else begin
            if (phase == 1) mtmp = mdl[sx];
            if (en) mdl[wa] = wd;
            done_exp = (phase == 2);
            case (phase)
                0: if (rf1.SwapReq) begin
                       phase = 1;
                       sx    = rf1.SwapAddrX;
                       sy    = rf1.SwapAddrY;
                   end
                1: phase = 2;
                default: phase = 0;
            endcase
        end
        @(negedge Clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        idle();
        rf1.WrEn   = 1'b1;
        rf1.WrAddr = a;
        rf1.DataIn = d;
        cycle();
        idle();
    endtask

    task automatic swap_req(input logic [3:0] x, input logic [3:0] y);
        idle();
        rf1.SwapReq   = 1'b1;
        rf1.SwapAddrX = x;
        rf1.SwapAddrY = y;
    endtask

    initial begin
        // Initial reset: DUT state is unknown until the first edge, so no checks
        idle();
        Reset = 1'b1;
        @(posedge Clk);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;

        // Everything reads zero after reset
        for (int i = 0; i < 16; i++) begin
            rf1.RdAddrA = 4'(i);
            #1 chk("rst_zero", rf1.DataOutA, 8'h00);
            cycle();
        end

        // Same-cycle bypass vs next-cycle visibility
        idle();
        rf1.WrEn = 1'b1; rf1.WrAddr = 4'd3; rf1.DataIn = 8'hA5; rf1.RdAddrA = 4'd3;
        #1;
        chk("byp_same",   rf1.DataOutA, 8'hA5);
        chk("nobyp_same", rf0.DataOutA, 8'h00);
        cycle();
        idle();
        rf1.RdAddrA = 4'd3;
        #1 chk("nobyp_next", rf0.DataOutA, 8'hA5);
        cycle();

        // Immediate beats external write
        idle();
        rf1.LoadImmEn = 1'b1; rf1.Imm = 6'h2A;
        rf1.WrEn = 1'b1; rf1.WrAddr = 4'd0; rf1.DataIn = 8'hFF;
        cycle();
        idle();
        #1 chk("prio_r0", rf0.DataOutA, 8'h2A);
        cycle();

        // Basic swap
        wr(4'd1, 8'h11);
        wr(4'd2, 8'h22);
        wr(4'd15, 8'h5A);
        swap_req(4'd1, 4'd2);
        cycle();
        idle();
        #1 chk("swap_busy1", 8'(rf1.Busy), 8'h01);
        cycle();
        #1 chk("swap_busy2", 8'(rf1.Busy), 8'h01);
        cycle();
        #1 chk("swap_done", 8'(rf1.SwapDone), 8'h01);
        chk("swap_idle", 8'(rf1.Busy), 8'h00);
        cycle();
        rf1.RdAddrA = 4'd1; rf1.RdAddrB = 4'd2; rf1.RdAddrC = 4'd15;
        #1;
        chk("swap_r1",  rf0.DataOutA, 8'h22);
        chk("swap_r2",  rf0.DataOutB, 8'h11);
        chk("swap_r15", rf0.DataOutC, 8'h5A);
        cycle();

        // External write held during busy is dropped
        swap_req(4'd1, 4'd2);
        cycle();
        idle();
        rf1.WrEn = 1'b1; rf1.WrAddr = 4'd5; rf1.DataIn = 8'h77;
        cycle();
        cycle();
        idle();
        rf1.RdAddrA = 4'd5;
        #1 chk("busy_drop_r5", rf0.DataOutA, 8'h00);
        cycle();

        // X == Y, then a back-to-back request in the SwapDone cycle
        wr(4'd4, 8'h3C);
        wr(4'd6, 8'h66);
        wr(4'd7, 8'h77);
        swap_req(4'd4, 4'd4);
        cycle();
        idle();
        cycle();
        cycle();
        #1 chk("xy_done", 8'(rf1.SwapDone), 8'h01);
        swap_req(4'd6, 4'd7);
        cycle();
        idle();
        #1 chk("b2b_busy", 8'(rf1.Busy), 8'h01);
        cycle();
        cycle();
        #1 chk("b2b_done", 8'(rf1.SwapDone), 8'h01);
        cycle();
        rf1.RdAddrA = 4'd4; rf1.RdAddrB = 4'd6; rf1.RdAddrC = 4'd7;
        #1;
        chk("xy_r4",  rf0.DataOutA, 8'h3C);
        chk("b2b_r6", rf0.DataOutB, 8'h77);
        chk("b2b_r7", rf0.DataOutC, 8'h66);
        cycle();

        // Reset during SWAP_A aborts the swap
        swap_req(4'd1, 4'd2);
        cycle();
        idle();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        #1;
        chk("mid_busy", 8'(rf1.Busy), 8'h00);
        chk("mid_done", 8'(rf1.SwapDone), 8'h00);
        for (int i = 0; i < 16; i++) begin
            rf1.RdAddrA = 4'(i);
            #1 chk("mid_zero", rf0.DataOutA, 8'h00);
            chk("mid_nodone", 8'(rf1.SwapDone), 8'h00);
            cycle();
        end

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            rf1.RdAddrA   = 4'($urandom);
            rf1.RdAddrB   = 4'($urandom);
            rf1.RdAddrC   = 4'($urandom);
            rf1.WrEn      = 1'($urandom_range(0, 1));
            rf1.WrAddr    = 4'($urandom);
            rf1.DataIn    = 8'($urandom);
            rf1.LoadImmEn = ($urandom_range(0, 7) == 0);
            rf1.Imm       = 6'($urandom);
            rf1.SwapReq   = ($urandom_range(0, 3) == 0);
            rf1.SwapAddrX = 4'($urandom);
            rf1.SwapAddrY = 4'($urandom);
            Reset         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        Reset = 1'b0;
        idle();
        cycle();
        cycle();
        for (int i = 0; i < 16; i++) begin
            rf1.RdAddrA = 4'(i);
            rf1.RdAddrB = 4'(15 - i);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_swap_seq
`default_nettype wire
